// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Helpers operate on maximum-width vectors so they serve any port count and weight width.
package wrr_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    localparam int MAX_PORTS    = 32;
    localparam int MAX_WEIGHT_W = 16;

    function automatic int onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

    // Port idx owns bits [idx*weight_w +: weight_w] of the packed weight vector.
    function automatic int weight_sel(input logic [MAX_PORTS*MAX_WEIGHT_W-1:0] weights,
                                      input int weight_w, input int idx);
        int w;
        w = 0;
        for (int b = 0; b < MAX_WEIGHT_W; b++) begin
            if (b < weight_w && weights[idx*weight_w + b]) begin
                w = w | (1 << b);
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first eligible port at or after ptr, wrapping.
// Zero latency; found is low only when no port is eligible.
module rr_pick
    import wrr_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] elig,
    input  logic [IDX_W-1:0]     ptr,
    output logic                 found,
    output logic [IDX_W-1:0]     idx
);

    logic [2*NUM_PORTS-1:0] dbl;
    logic [2*NUM_PORTS-1:0] keep;
    logic [2*NUM_PORTS-1:0] masked;
    logic [2*NUM_PORTS-1:0] first;
    logic [NUM_PORTS-1:0]   folded;

    // Low copy only keeps ports at or above ptr; the high copy supplies the wrapped ones.
    always_comb begin
        keep = '0;
        for (int i = 0; i < 2*NUM_PORTS; i++) begin
            keep[i] = (i >= NUM_PORTS) || (i >= int'(ptr));
        end
    end

    assign dbl    = {elig, elig};
    assign masked = dbl & keep;
    assign first  = masked & (~masked + (2*NUM_PORTS)'(1));
    assign folded = first[NUM_PORTS-1:0] | first[2*NUM_PORTS-1:NUM_PORTS];
    assign found  = |elig;
    assign idx    = IDX_W'(onehot_to_idx(MAX_PORTS'(folded)));

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: grants one port for up to weight packets per turn.
// Grant appears 1 cycle after request; one idle cycle separates consecutive grants.
module wrr_arbiter
    import wrr_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    parameter  int WEIGHT_W  = 4,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req_i,
    input  logic [NUM_PORTS-1:0]          mask_i,
    input  logic [NUM_PORTS*WEIGHT_W-1:0] weight_i,
    input  logic                          ack_i,
    input  logic                          last_i,
    output logic [NUM_PORTS-1:0]          gnt_o,
    output logic [IDX_W-1:0]              gnt_id_o,
    output logic                          gnt_valid_o
);

    state_t               state;
    logic [IDX_W-1:0]     ptr;
    logic [WEIGHT_W-1:0]  credit;
    logic [NUM_PORTS-1:0] elig;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [WEIGHT_W-1:0]  pick_weight;
    logic                 own_req;
    logic                 release_now;

    assign elig        = req_i & ~mask_i;
    assign pick_weight = WEIGHT_W'(weight_sel((MAX_PORTS*MAX_WEIGHT_W)'(weight_i),
                                              WEIGHT_W, int'(pick_idx)));
    assign own_req     = req_i[gnt_id_o];
    assign gnt_valid_o = |gnt_o;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .elig  (elig),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // A withdrawn request without an ack ends the turn without charging credit.
    always_comb begin
        release_now = 1'b0;
        if (ack_i && last_i) begin
            release_now = !(credit > WEIGHT_W'(1) && own_req);
        end else if (!ack_i && !own_req) begin
            release_now = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            credit   <= '0;
            gnt_o    <= '0;
            gnt_id_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt_o    <= NUM_PORTS'(1) << pick_idx;
                        gnt_id_o <= pick_idx;
                        credit   <= (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt_o    <= '0;
                        gnt_id_o <= '0;
                        ptr      <= (gnt_id_o == IDX_W'(NUM_PORTS-1)) ? '0
                                                                      : gnt_id_o + IDX_W'(1);
                        state    <= IDLE;
                    end else if (ack_i && last_i) begin
                        credit <= credit - WEIGHT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed and randomised checks of the weighted round-robin arbiter (4 ports, 4-bit weights).
module tb_wrr_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_i = '0;
    logic [N-1:0]   mask_i = '0;
    logic [N*W-1:0] weight_i = '0;
    logic           ack_i = 1'b0;
    logic           last_i = 1'b0;
    logic [N-1:0]   gnt_o;
    logic [1:0]     gnt_id_o;
    logic           gnt_valid_o;
    logic [6:0]     obs;

    int total = 0;
    int bad   = 0;

    wrr_arbiter #(.NUM_PORTS(N), .WEIGHT_W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .mask_i      (mask_i),
        .weight_i    (weight_i),
        .ack_i       (ack_i),
        .last_i      (last_i),
        .gnt_o       (gnt_o),
        .gnt_id_o    (gnt_id_o),
        .gnt_valid_o (gnt_valid_o)
    );

    always #5 clk = ~clk;

    assign obs = {gnt_valid_o, gnt_id_o, gnt_o};

    // Expected {valid, id, grant} for a given expected grant vector.
    function automatic logic [6:0] exp_of(input logic [N-1:0] g);
        logic [1:0] id;
        id = 2'd0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) id = 2'(i);
        end
        return {|g, id, g};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; req_i = '0; mask_i = '0; weight_i = '0; ack_i = 1'b0; last_i = 1'b0;
        step;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_i = 4'b1111; weight_i = 16'h1111;
        #2;
        total++;
        if (obs !== exp_of(4'b0000)) begin
            bad++; $display("FAIL reset_level got=%b exp=%b", obs, exp_of(4'b0000));
        end
        step;
        total++;
        if (obs !== exp_of(4'b0000)) begin
            bad++; $display("FAIL reset_edge got=%b exp=%b", obs, exp_of(4'b0000));
        end
        reset = 1'b0;
        step;
        total++;
        if (obs !== exp_of(4'b0001)) begin
            bad++; $display("FAIL first_grant got=%b exp=%b", obs, exp_of(4'b0001));
        end
    endtask

    task automatic test_rotation;
        logic [N-1:0] order [5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset;
        weight_i = 16'h1111; req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step;
            total++;
            if (obs !== exp_of(order[k])) begin
                bad++; $display("FAIL rot_gnt[%0d] got=%b exp=%b", k, obs, exp_of(order[k]));
            end
            ack_i = 1'b1; last_i = 1'b1;
            step;
            total++;
            if (obs !== exp_of(4'b0000)) begin
                bad++; $display("FAIL rot_bubble[%0d] got=%b exp=%b", k, obs, exp_of(4'b0000));
            end
            ack_i = 1'b0; last_i = 1'b0;
        end
    endtask

    task automatic test_weighting;
        logic [N-1:0] seq [12];
        seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0000,
                4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        do_reset;
        weight_i = {4'd2, 4'd0, 4'd1, 4'd3};
        req_i = 4'b1111; ack_i = 1'b1; last_i = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step;
            total++;
            if (obs !== exp_of(seq[k])) begin
                bad++; $display("FAIL weight_seq[%0d] got=%b exp=%b", k, obs, exp_of(seq[k]));
            end
        end
        ack_i = 1'b0; last_i = 1'b0;
    endtask

    task automatic test_multibeat_withdraw;
        do_reset;
        weight_i = 16'h0200; req_i = 4'b0100;
        step;
        total++;
        if (obs !== exp_of(4'b0100)) begin
            bad++; $display("FAIL mb_grant got=%b exp=%b", obs, exp_of(4'b0100));
        end
        ack_i = 1'b1; last_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b == 3) last_i = 1'b1;
            step;
            total++;
            if (obs !== exp_of(4'b0100)) begin
                bad++; $display("FAIL mb_beat[%0d] got=%b exp=%b", b, obs, exp_of(4'b0100));
            end
        end
        ack_i = 1'b0; last_i = 1'b0; req_i = 4'b0000;
        step;
        total++;
        if (obs !== exp_of(4'b0000)) begin
            bad++; $display("FAIL withdraw_release got=%b exp=%b", obs, exp_of(4'b0000));
        end
        req_i = 4'b1001;
        step;
        total++;
        if (obs !== exp_of(4'b1000)) begin
            bad++; $display("FAIL withdraw_ptr got=%b exp=%b", obs, exp_of(4'b1000));
        end
    endtask

    task automatic test_mask_wrap;
        logic [N-1:0] exp_g [8];
        exp_g = '{4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        do_reset;
        weight_i = 16'h1111;
        for (int k = 0; k < 8; k++) begin
            case (k)
                0: req_i = 4'b0100;
                1: begin ack_i = 1'b1; last_i = 1'b1; end
                2: begin ack_i = 1'b0; last_i = 1'b0; req_i = 4'b1001; mask_i = 4'b0001; end
                3: begin ack_i = 1'b1; last_i = 1'b1; end
                4: begin ack_i = 1'b0; last_i = 1'b0; end
                5: mask_i = 4'b0000;
                6: begin ack_i = 1'b1; last_i = 1'b1; end
                default: begin ack_i = 1'b0; last_i = 1'b0; end
            endcase
            step;
            total++;
            if (obs !== exp_of(exp_g[k])) begin
                bad++; $display("FAIL mask_wrap[%0d] got=%b exp=%b", k, obs, exp_of(exp_g[k]));
            end
        end
    endtask

    task automatic test_async_reset;
        do_reset;
        weight_i = 16'h1111; req_i = 4'b0010;
        step;
        total++;
        if (obs !== exp_of(4'b0010)) begin
            bad++; $display("FAIL ar_grant got=%b exp=%b", obs, exp_of(4'b0010));
        end
        #3 reset = 1'b1;
        #1;
        total++;
        if (obs !== exp_of(4'b0000)) begin
            bad++; $display("FAIL ar_immediate got=%b exp=%b", obs, exp_of(4'b0000));
        end
        step;
        reset = 1'b0;
        step;
        total++;
        if (obs !== exp_of(4'b0010)) begin
            bad++; $display("FAIL ar_regrant got=%b exp=%b", obs, exp_of(4'b0010));
        end
    endtask

    task automatic test_idle_inputs;
        do_reset;
        weight_i = 16'h1111;
        for (int k = 0; k < 4; k++) begin
            ack_i = k[0]; last_i = 1'b1;
            step;
            total++;
            if (obs !== exp_of(4'b0000)) begin
                bad++; $display("FAIL idle_ack[%0d] got=%b exp=%b", k, obs, exp_of(4'b0000));
            end
        end
        ack_i = 1'b0; last_i = 1'b0; req_i = 4'b0011;
        step;
        total++;
        if (obs !== exp_of(4'b0001)) begin
            bad++; $display("FAIL idle_ptr got=%b exp=%b", obs, exp_of(4'b0001));
        end
    endtask

    task automatic test_random;
        int           cnt [N];
        logic [N-1:0] prev_g;
        logic [N-1:0] elig_drv;
        do_reset;
        prev_g = '0;
        for (int p = 0; p < N; p++) cnt[p] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N; p++) begin
                req_i[p]  = ($urandom_range(0, 9) != 0);
                mask_i[p] = ($urandom_range(0, 9) == 0);
                weight_i[p*W +: W] = W'($urandom_range(0, 3));
            end
            ack_i  = 1'($urandom_range(0, 1));
            last_i = 1'($urandom_range(0, 1));
            elig_drv = req_i & ~mask_i;
            for (int p = 0; p < N; p++) begin
                if (!elig_drv[p]) cnt[p] = 0;
            end
            step;
            total++;
            if ((gnt_o & (gnt_o - 4'd1)) !== 4'b0000) begin
                bad++; $display("FAIL rnd_onehot[%0d] got=%b exp=zero_or_onehot", c, gnt_o);
            end
            total++;
            if (obs !== exp_of(gnt_o)) begin
                bad++; $display("FAIL rnd_consistent[%0d] got=%b exp=%b", c, obs, exp_of(gnt_o));
            end
            if (prev_g == '0 && gnt_o != '0) begin
                for (int p = 0; p < N; p++) begin
                    if (gnt_o[p]) begin
                        cnt[p] = 0;
                    end else if (elig_drv[p]) begin
                        cnt[p]++;
                        total++;
                        if (cnt[p] > N - 1) begin
                            bad++;
                            $display("FAIL rnd_fair[%0d] port=%0d waited=%0d max=%0d", c, p, cnt[p], N - 1);
                        end
                    end
                end
            end
            prev_g = gnt_o;
        end
        req_i = '0; mask_i = '0; ack_i = 1'b0; last_i = 1'b0;
    endtask

    initial begin
        test_reset;
        test_rotation;
        test_weighting;
        test_multibeat_withdraw;
        test_mask_wrap;
        test_async_reset;
        test_idle_inputs;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
- Parametrised weighted round-robin arbiter. It is the successor to the plain rotating-priority arbiter.
- It grants one of NUM_PORTS requesters a shared resource and holds the grant across multi-beat packets.
- It allows each port up to a programmable number of packets per turn before rotating priority.
- It sits between requesting client channels and a shared bus/port mux. It drives mux select via gnt_id_o.

Parameters:
- NUM_PORTS, 4, number of requesters (>=2).
- WEIGHT_W, 4, width of each per-port weight field. Weight is packets per turn.
- IDX_W, $clog2(NUM_PORTS), width of the port index (derived, not overridden).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req_i  in  NUM_PORTS  per-port request level. Held high while the port has data.
- mask_i  in  NUM_PORTS  1 = port excluded from arbitration.
- weight_i  in  NUM_PORTS*WEIGHT_W  per-port weight. Port i occupies bits [i*WEIGHT_W +: WEIGHT_W].
- ack_i  in  1  beat accepted by the shared resource this cycle.
- last_i  in  1  qualifies ack_i: final beat of the packet.
- gnt_o  out  NUM_PORTS  one-hot grant, registered.
- gnt_id_o  out  IDX_W  index of the granted port. Valid when gnt_valid_o=1, otherwise 0.
- gnt_valid_o  out  1  a grant is active (equal to |gnt_o).

Behaviour:
- Reset (async, immediate):
  - gnt_o=0, gnt_id_o=0, gnt_valid_o=0.
  - ptr=0, credit=0, state=IDLE.
- Eligible vector: elig = req_i & ~mask_i.
- State IDLE:
  - If elig!=0, search circularly from ptr (ptr, ptr+1, ... wrapping modulo NUM_PORTS). Pick the first eligible port k.
  - Next edge: gnt_o=onehot(k), gnt_id_o=k, credit=weight[k] (a weight of 0 loads 1), state=GRANT.
  - Latency is 1 cycle from req_i high to gnt_o high.
  - If elig==0, stay in IDLE with outputs at 0.
- State GRANT (owner k):
  - The grant is held unconditionally between packets. mask_i changes do not revoke an active grant.
  - ack_i && last_i && credit>1 && req_i[k]: credit decrements, grant held.
  - ack_i && last_i && (credit==1 || !req_i[k]): release.
  - ack_i && !last_i: no state change.
  - !ack_i && !req_i[k]: owner withdrew. Release, with no credit charged.
  - Otherwise hold.
- Release:
  - Next edge: gnt_o=0, gnt_valid_o=0, gnt_id_o=0, ptr=(k+1) mod NUM_PORTS (wraps N-1 -> 0), state=IDLE.
  - There is exactly one idle bubble cycle between grants.
- ack_i/last_i while in IDLE are ignored.
- weight_i is sampled only at grant issue. Changes mid-turn take effect at the next grant to that port.
- The credit counter is WEIGHT_W bits and never underflows. The minimum loaded value is 1.
- Fairness guarantee: each continuously requesting, unmasked port is granted within (NUM_PORTS-1) turns of other ports.
- Reset asserted mid-packet drops the grant immediately. The client must treat the packet as aborted.
- Invariants:
  - gnt_o is always zero or one-hot.
  - gnt_o[k]=1 implies gnt_id_o=k.

Decomposition:
- Shared package wrr_pkg:
  - state enum {IDLE, GRANT}.
  - A function onehot_to_idx.
  - A function weight_sel(weight_i, idx).
- One sub-module: rr_pick. This is a combinational rotating-priority picker with inputs (elig, ptr) and outputs (found, idx). It is implemented as a doubled-vector mask or rotate-then-priority-encode.
- The credit counter, FSM and output registers live in wrr_arbiter.

Test Plan (NUM_PORTS=4, WEIGHT_W=4):
- Scenario 1, basic rotation:
  - Stimulus: reset, then req_i=4'b1111, weights all 1, ack_i&last_i asserted one cycle after each grant.
  - Required: grant order 0,1,2,3,0 with one bubble between grants; gnt_id_o 0,1,2,3,0.
- Scenario 2, weighting:
  - Stimulus: weights {p0=3, p1=1, p2=0, p3=2}, req_i=1111, single-beat packets.
  - Required: per turn p0 holds for 3 packets, p1 for 1, p2 for 1 (weight 0 treated as 1), p3 for 2, then back to p0.
- Scenario 3, multi-beat and withdraw:
  - Stimulus: p2 granted, 4 beats with last_i only on beat 4, weight 2.
  - Required: grant held through all beats, credit 2->1.
  - Stimulus: p2 then drops req_i with no ack.
  - Required: gnt_o=0 next edge, ptr=3.
- Scenario 4, mask and wrap:
  - Stimulus: mask_i=4'b0001, req_i=1001, ptr=3.
  - Required: p3 granted; p0 is never granted while masked.
  - Stimulus: mask_i=0.
  - Required: after p3 releases, p0 is granted (ptr wraps 3->0).
- Scenario 5, async reset mid-grant:
  - Stimulus: assert reset mid-cycle while p1 is granted.
  - Required: gnt_o=0, gnt_valid_o=0 immediately (before the next edge).
  - Stimulus: release reset with req_i=0010.
  - Required: p1 granted 1 cycle later (ptr=0 search).
- Scenario 6, idle inputs and random check:
  - Stimulus: ack_i/last_i pulsing while in IDLE with req_i=0.
  - Required: no state change.
  - Stimulus: random req/ack/mask/weights.
  - Required: assertions hold for one-hot, gnt_id/gnt_o consistency, and fairness bound.
